// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chess_pkg
// Brief    : Shared state encoding and timing constants for the chess timer.
// Revision : 1.0 - initial release
// ============================================================================
package chess_pkg;

  // Turn-controller states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN_A = 3'd1,
    ST_RUN_B = 3'd2,
    ST_PAUSE = 3'd3,
    ST_FLAG  = 3'd4
  } state_e;

  // Default starting time per player in centiseconds (5 minutes)
  localparam int unsigned DEF_TIME_CS = 30000;

  // Rate of the shared tick strobe from the divider stage
  localparam int unsigned TICK_HZ = 100;

endpackage
`default_nettype wire

// File: rtl/edge_det.sv
`default_nettype none
// ============================================================================
// Module   : edge_det
// Brief    : Rising-edge detector against a one-cycle-delayed copy. The copy
//            resets high so a level already asserted at reset gives no edge.
// Revision : 1.0 - initial release
// ============================================================================
module edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Delayed copy of the input; reset high to suppress an edge on held levels
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule
`default_nettype wire

// File: rtl/chess_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chess_turn_ctrl
// Brief    : Chess timer turn controller. Routes the 100 Hz tick to the
//            player on move, sequences IDLE/RUN/PAUSE/FLAG and applies a
//            saturating Fischer increment on each move.
// Revision : 1.0 - initial release
// ============================================================================
module chess_turn_ctrl
  import chess_pkg::*;
#(
  parameter int unsigned TIME_W   = 20,
  parameter int unsigned DEF_TIME = DEF_TIME_CS,
  parameter int unsigned INC_CS   = 0
) (
  input  logic              clkIn,
  input  logic              rstN,
  input  logic              tickIn,
  input  logic              btnA,
  input  logic              btnB,
  input  logic              startIn,
  input  logic              pauseIn,
  input  logic              loadIn,
  input  logic [TIME_W-1:0] timeIn,
  output logic [TIME_W-1:0] timeA,
  output logic [TIME_W-1:0] timeB,
  output logic              turnB,
  output logic              running,
  output logic              flagA,
  output logic              flagB
);

  // Two guard bits: one for the increment carry, one for the tick borrow
  localparam logic [TIME_W+1:0] C_INC = (TIME_W+2)'(INC_CS);
  localparam logic [TIME_W+1:0] C_MAX = {2'b00, {TIME_W{1'b1}}};
  localparam logic [TIME_W-1:0] C_DEF = TIME_W'(DEF_TIME);
  localparam logic [TIME_W-1:0] C_ONE = TIME_W'(1);

  state_e            state_q;
  logic [TIME_W-1:0] timeA_q;
  logic [TIME_W-1:0] timeB_q;
  logic              turnB_q;
  logic              running_q;
  logic              flagA_q;
  logic              flagB_q;

  logic btnA_e;
  logic btnB_e;
  logic start_e;
  logic pause_e;
  logic load_e;

  edge_det u_ed_btn_a (.clk_i(clkIn), .rst_ni(rstN), .d_i(btnA),    .rise_o(btnA_e));
  edge_det u_ed_btn_b (.clk_i(clkIn), .rst_ni(rstN), .d_i(btnB),    .rise_o(btnB_e));
  edge_det u_ed_start (.clk_i(clkIn), .rst_ni(rstN), .d_i(startIn), .rise_o(start_e));
  edge_det u_ed_pause (.clk_i(clkIn), .rst_ni(rstN), .d_i(pauseIn), .rise_o(pause_e));
  edge_det u_ed_load  (.clk_i(clkIn), .rst_ni(rstN), .d_i(loadIn),  .rise_o(load_e));

  // Time after a move: t - tick + increment, clamped to the counter maximum.
  // Callers only pass tk=1 when t is non-zero, so the sum never borrows.
  function automatic logic [TIME_W-1:0] move_time(input logic [TIME_W-1:0] t,
                                                   input logic tk);
    logic [TIME_W+1:0] s;
    s = {2'b00, t} + C_INC - {{(TIME_W+1){1'b0}}, tk};
    if (s > C_MAX) begin
      move_time = {TIME_W{1'b1}};
    end else begin
      move_time = s[TIME_W-1:0];
    end
  endfunction

  // Per-player counter candidates; a tick on an empty counter is never applied
  logic              tickA_d;
  logic              tickB_d;
  logic              lastA_d;
  logic              lastB_d;
  logic [TIME_W-1:0] decA_d;
  logic [TIME_W-1:0] decB_d;
  logic [TIME_W-1:0] moveA_d;
  logic [TIME_W-1:0] moveB_d;

  assign tickA_d = tickIn & (timeA_q != '0);
  assign tickB_d = tickIn & (timeB_q != '0);
  assign lastA_d = tickIn & (timeA_q == C_ONE);
  assign lastB_d = tickIn & (timeB_q == C_ONE);
  assign decA_d  = timeA_q - C_ONE;
  assign decB_d  = timeB_q - C_ONE;
  assign moveA_d = move_time(timeA_q, tickA_d);
  assign moveB_d = move_time(timeB_q, tickB_d);

  // Game sequencer with both countdown counters and all registered outputs
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      state_q   <= ST_IDLE;
      timeA_q   <= C_DEF;
      timeB_q   <= C_DEF;
      turnB_q   <= 1'b0;
      running_q <= 1'b0;
      flagA_q   <= 1'b0;
      flagB_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_e) begin
            timeA_q <= timeIn;
            timeB_q <= timeIn;
          end else if (start_e) begin
            turnB_q <= 1'b0;
            if (timeA_q == '0) begin
              state_q <= ST_FLAG;
              flagA_q <= 1'b1;
            end else begin
              state_q   <= ST_RUN_A;
              running_q <= 1'b1;
            end
          end
        end

        ST_RUN_A: begin
          if (lastA_d) begin
            timeA_q   <= '0;
            flagA_q   <= 1'b1;
            state_q   <= ST_FLAG;
            running_q <= 1'b0;
          end else if (pause_e) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end else if (btnA_e) begin
            timeA_q <= moveA_d;
            state_q <= ST_RUN_B;
            turnB_q <= 1'b1;
          end else if (tickA_d) begin
            timeA_q <= decA_d;
          end
        end

        ST_RUN_B: begin
          if (lastB_d) begin
            timeB_q   <= '0;
            flagB_q   <= 1'b1;
            state_q   <= ST_FLAG;
            running_q <= 1'b0;
          end else if (pause_e) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end else if (btnB_e) begin
            timeB_q <= moveB_d;
            state_q <= ST_RUN_A;
            turnB_q <= 1'b0;
          end else if (tickB_d) begin
            timeB_q <= decB_d;
          end
        end

        ST_PAUSE: begin
          if (pause_e) begin
            state_q   <= turnB_q ? ST_RUN_B : ST_RUN_A;
            running_q <= 1'b1;
          end else if (load_e) begin
            state_q <= ST_IDLE;
            timeA_q <= timeIn;
            timeB_q <= timeIn;
            turnB_q <= 1'b0;
          end
        end

        ST_FLAG: begin
          if (load_e) begin
            state_q <= ST_IDLE;
            timeA_q <= timeIn;
            timeB_q <= timeIn;
            turnB_q <= 1'b0;
            flagA_q <= 1'b0;
            flagB_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign timeA   = timeA_q;
  assign timeB   = timeB_q;
  assign turnB   = turnB_q;
  assign running = running_q;
  assign flagA   = flagA_q;
  assign flagB   = flagB_q;

endmodule
`default_nettype wire

// File: tb/tb_chess_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chess_turn_ctrl
// Brief    : Self-checking bench for chess_turn_ctrl. Two instances (no
//            increment and a 5 cs increment) share the same stimulus and are
//            compared every cycle against a behavioural game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chess_turn_ctrl;

  localparam int TW   = 20;
  localparam int MAXV = (1 << TW) - 1;
  localparam int DEFT = 30000;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_FLAG  = 3;

  // Event bits: {tick, btnA, btnB, start, pause, load}
  localparam logic [5:0] TK = 6'b100000;
  localparam logic [5:0] BA = 6'b010000;
  localparam logic [5:0] BB = 6'b001000;
  localparam logic [5:0] ST = 6'b000100;
  localparam logic [5:0] PS = 6'b000010;
  localparam logic [5:0] LD = 6'b000001;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          tickIn = 1'b0, btnA = 1'b0, btnB = 1'b0;
  logic          startIn = 1'b0, pauseIn = 1'b0, loadIn = 1'b0;
  logic [TW-1:0] timeIn = '0;

  logic [TW-1:0] timeA0, timeB0, timeA5, timeB5;
  logic          turnB0, running0, flagA0, flagB0;
  logic          turnB5, running5, flagA5, flagB5;

  always #5 clk = ~clk;

  chess_turn_ctrl #(.TIME_W(TW), .DEF_TIME(DEFT), .INC_CS(0)) dut0 (
    .clkIn(clk), .rstN(rstN), .tickIn(tickIn), .btnA(btnA), .btnB(btnB),
    .startIn(startIn), .pauseIn(pauseIn), .loadIn(loadIn), .timeIn(timeIn),
    .timeA(timeA0), .timeB(timeB0), .turnB(turnB0), .running(running0),
    .flagA(flagA0), .flagB(flagB0)
  );

  chess_turn_ctrl #(.TIME_W(TW), .DEF_TIME(DEFT), .INC_CS(5)) dut5 (
    .clkIn(clk), .rstN(rstN), .tickIn(tickIn), .btnA(btnA), .btnB(btnB),
    .startIn(startIn), .pauseIn(pauseIn), .loadIn(loadIn), .timeIn(timeIn),
    .timeA(timeA5), .timeB(timeB5), .turnB(turnB5), .running(running5),
    .flagA(flagA5), .flagB(flagB5)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int inc_of [2] = '{0, 5};
  int m_mode [2];
  int m_mover[2];          // index of player on move: 0 = A, 1 = B
  int m_t    [2][2];       // [instance][player] remaining centiseconds
  int m_f    [2][2];       // [instance][player] flag fallen
  bit p_bA, p_bB, p_st, p_ps, p_ld;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d]  = M_IDLE;
      m_mover[d] = 0;
      for (int p = 0; p < 2; p++) begin
        m_t[d][p] = DEFT;
        m_f[d][p] = 0;
      end
    end
    p_bA = 1; p_bB = 1; p_st = 1; p_ps = 1; p_ld = 1;
  endtask

  task automatic load_both(input int d);
    m_t[d][0] = int'(timeIn);
    m_t[d][1] = int'(timeIn);
  endtask

  task automatic model_step(input int d, input bit eA, input bit eB,
                            input bit eS, input bit eP, input bit eL);
    int m, tk, v;
    bit mine;
    case (m_mode[d])
      M_IDLE: begin
        if (eL) load_both(d);
        else if (eS) begin
          m_mover[d] = 0;
          if (m_t[d][0] == 0) begin m_mode[d] = M_FLAG; m_f[d][0] = 1; end
          else m_mode[d] = M_RUN;
        end
      end
      M_RUN: begin
        m    = m_mover[d];
        mine = (m == 0) ? eA : eB;
        tk   = (tickIn && m_t[d][m] > 0) ? 1 : 0;
        if (tk == 1 && m_t[d][m] == 1) begin
          m_t[d][m] = 0; m_f[d][m] = 1; m_mode[d] = M_FLAG;
        end else if (eP) begin
          m_mode[d] = M_PAUSE;
        end else if (mine) begin
          v = m_t[d][m] - tk + inc_of[d];
          if (v > MAXV) v = MAXV;
          m_t[d][m]  = v;
          m_mover[d] = 1 - m;
        end else begin
          m_t[d][m] = m_t[d][m] - tk;
        end
      end
      M_PAUSE: begin
        if (eP) m_mode[d] = M_RUN;
        else if (eL) begin m_mode[d] = M_IDLE; load_both(d); m_mover[d] = 0; end
      end
      default: begin
        if (eL) begin
          m_mode[d] = M_IDLE; load_both(d); m_mover[d] = 0;
          m_f[d][0] = 0; m_f[d][1] = 0;
        end
      end
    endcase
  endtask

  task automatic cmp(input int d, input logic [TW-1:0] ta, input logic [TW-1:0] tb,
                     input logic tu, input logic ru, input logic fa, input logic fb);
    string s;
    s = (d == 0) ? "inc0" : "inc5";
    chk({s, ".timeA"},   ta, m_t[d][0]);
    chk({s, ".timeB"},   tb, m_t[d][1]);
    chk({s, ".turnB"},   tu, m_mover[d]);
    chk({s, ".running"}, ru, (m_mode[d] == M_RUN) ? 1 : 0);
    chk({s, ".flagA"},   fa, m_f[d][0]);
    chk({s, ".flagB"},   fb, m_f[d][1]);
  endtask

  // Model advance and per-cycle compare, on the falling edge
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rstN) begin
        model_reset();
      end else begin
        for (int d = 0; d < 2; d++)
          model_step(d, btnA & ~p_bA, btnB & ~p_bB, startIn & ~p_st,
                     pauseIn & ~p_ps, loadIn & ~p_ld);
        p_bA = btnA; p_bB = btnB; p_st = startIn; p_ps = pauseIn; p_ld = loadIn;
      end
      cmp(0, timeA0, timeB0, turnB0, running0, flagA0, flagB0);
      cmp(1, timeA5, timeB5, turnB5, running5, flagA5, flagB5);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic pulse(input logic [5:0] v);
    {tickIn, btnA, btnB, startIn, pauseIn, loadIn} = v;
    step();
    {tickIn, btnA, btnB, startIn, pauseIn, loadIn} = 6'b0;
    step();
  endtask

  initial begin
    repeat (3) step();
    rstN = 1'b1;
    step();
    chk("reset timeA", timeA0, DEFT);
    chk("reset running", running0, 0);

    // Reset and load; ticks in IDLE are ignored
    timeIn = 500;
    pulse(LD);
    pulse(TK);
    chk("load timeA", timeA0, 500);
    chk("load timeB", timeB0, 500);
    chk("load flagA", flagA0, 0);

    // Run and switch
    pulse(ST);
    repeat (3) pulse(TK);
    chk("run timeA", timeA0, 497);
    chk("run running", running0, 1);
    pulse(BA);
    chk("switch turnB", turnB0, 1);
    chk("switch inc5 timeA", timeA5, 502);
    repeat (2) pulse(TK);
    chk("runB timeB", timeB0, 498);

    // Pause and ignored inputs in RUN_B
    pulse(PS);
    chk("pause running", running0, 0);
    repeat (4) pulse(TK);
    pulse(BA); pulse(ST); pulse(BB);
    chk("paused timeB", timeB0, 498);
    pulse(PS);
    chk("resume turnB", turnB5, 1);
    pulse(TK);
    chk("resume timeB", timeB0, 497);

    // Flag fall
    pulse(PS);
    timeIn = 2;
    pulse(LD);
    pulse(ST);
    repeat (2) pulse(TK);
    chk("flag timeA", timeA0, 0);
    chk("flag flagA", flagA0, 1);
    pulse(TK); pulse(BA); pulse(ST); pulse(PS); pulse(BB);
    chk("flag frozen running", running0, 0);
    timeIn = 10;
    pulse(LD);
    chk("reload flagA", flagA0, 0);
    chk("reload timeA", timeA5, 10);

    // Simultaneous tick and move
    pulse(ST);
    pulse(TK | BA);
    chk("tick+move inc5 timeA", timeA5, 14);
    chk("tick+move inc0 timeA", timeA0, 9);
    pulse(PS);
    timeIn = 1;
    pulse(LD);
    pulse(ST);
    pulse(TK | BA);
    chk("last tick+move flagA", flagA5, 1);
    chk("last tick+move turnB", turnB5, 0);

    // Pause wins over same-cycle tick
    timeIn = 3;
    pulse(LD);
    pulse(ST);
    pulse(TK | PS);
    chk("pause+tick timeA", timeA0, 3);

    // Saturation
    timeIn = TW'(MAXV - 2);
    pulse(LD);
    pulse(ST);
    pulse(BA);
    chk("sat inc5 timeA", timeA5, MAXV);
    chk("sat inc0 timeA", timeA0, MAXV - 2);
    pulse(BB);
    pulse(TK);

    // Asynchronous reset in RUN_A, with buttons held through release
    rstN = 1'b0; btnA = 1'b1; startIn = 1'b1;
    #1;
    chk("async rst timeA", timeA5, DEFT);
    chk("async rst running", running0, 0);
    repeat (2) step();
    rstN = 1'b1;
    repeat (3) step();
    chk("held start running", running0, 0);
    chk("held btn turnB", turnB0, 0);
    btnA = 1'b0; startIn = 1'b0;
    step();
    pulse(ST);
    chk("post reset start", running0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Run-time guard
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
